keypad_scanner: RTL

- Scans a 4x4 matrix keypad (Pmod KYPD style) by driving columns and reading rows, then debounces the result.
- Reports a single debounced key as a 4-bit code, with press and release pulses.
- Input-side counterpart to the multiplexed seven-segment driver: same 100 MHz clock and the same 1 ms per-slot scan timing, applied in the reading direction.
- Its outputs feed the simulator control logic and the display data path.

---
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and reports one debounced key.
// Define KEYPAD_REPEAT_EN to re-pulse key_pressed every REPEAT_SCANS held slots.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 500
) (
    input  logic       clk100mhz,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed,
    output logic       key_released
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS - 1);

    if (SCAN_TICKS < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: parameter below minimum");
    end

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD} state_t;

    state_t        state, state_n;
    logic [1:0]    col_idx, col_idx_n, cand_row, cand_row_n, cand_col, cand_col_n, first_row;
    logic [TW-1:0] timer, timer_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n, key_pressed_n, key_released_n, slot_end, accept;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
    logic [RW-1:0] rep, rep_n;
`endif

    assign col       = ~(4'b0001 << col_idx);
    assign slot_end  = timer == TICK_LAST;
    assign first_row = !row[0] ? 2'd0 : !row[1] ? 2'd1 : !row[2] ? 2'd2 : 2'd3;

    always_comb begin
        state_n        = state;
        col_idx_n      = col_idx;
        cnt_n          = cnt;
        cand_row_n     = cand_row;
        cand_col_n     = cand_col;
        key_code_n     = key_code;
        key_valid_n    = key_valid;
        key_pressed_n  = 1'b0;
        key_released_n = 1'b0;
        accept         = 1'b0;
        timer_n        = slot_end ? '0 : timer + 1'b1;
`ifdef KEYPAD_REPEAT_EN
        rep_n          = rep;
`endif
        if (slot_end) begin
            case (state)
                SCAN: begin
                    if (row != 4'hF) begin
                        cand_row_n = first_row;
                        cand_col_n = col_idx;
                        cnt_n      = CW'(1);
                        state_n    = PRESS_DB;
                        accept     = DEBOUNCE_SCANS == 1;
                    end else begin
                        col_idx_n = col_idx + 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!row[cand_row]) begin
                        cnt_n  = cnt + 1'b1;
                        accept = cnt == DB_LAST;
                    end else begin
                        state_n   = SCAN;
                        cnt_n     = '0;
                        col_idx_n = col_idx + 1'b1;
                    end
                end
                HELD: begin
                    if (row[cand_row]) begin
                        cnt_n = cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_n = '0;
`endif
                        if (cnt == DB_LAST) begin
                            state_n        = SCAN;
                            cnt_n          = '0;
                            col_idx_n      = col_idx + 1'b1;
                            key_valid_n    = 1'b0;
                            key_released_n = 1'b1;
                        end
                    end else begin
                        cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_n         = rep == REP_LAST ? '0 : rep + 1'b1;
                        key_pressed_n = rep == REP_LAST;
`endif
                    end
                end
                default: state_n = SCAN;
            endcase
            // cnt is reused as the release counter once the key is held
            if (accept) begin
                state_n       = HELD;
                cnt_n         = '0;
                key_code_n    = {cand_col_n, cand_row_n};
                key_valid_n   = 1'b1;
                key_pressed_n = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_n         = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state        <= SCAN;
            col_idx      <= '0;
            timer        <= '0;
            cnt          <= '0;
            cand_row     <= '0;
            cand_col     <= '0;
            key_code     <= '0;
            key_valid    <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep          <= '0;
`endif
        end else begin
            state        <= state_n;
            col_idx      <= col_idx_n;
            timer        <= timer_n;
            cnt          <= cnt_n;
            cand_row     <= cand_row_n;
            cand_col     <= cand_col_n;
            key_code     <= key_code_n;
            key_valid    <= key_valid_n;
            key_pressed  <= key_pressed_n;
            key_released <= key_released_n;
`ifdef KEYPAD_REPEAT_EN
            rep          <= rep_n;
`endif
        end
    end
endmodule
